sdram_arbiter: RTL and testbench

Sequences and shares the single SDRAM controller command port between three sources: memory initializer, frame reader and fractal processor.
- Replaces the combinational select/yield scheme with an explicit request/grant handshake.
- Tracks each outstanding transaction to completion before ownership changes hands.
- Sits between the requesters and as4c4m32s_controller in the MEM_CLK domain.

---
 rtl/sdram_pkg.sv | 45 ++++
 rtl/sdram_arbiter_if.sv | 55 +++++
 rtl/sdram_arbiter_txn_tracker.sv | 75 +++++++
 rtl/sdram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM command-port arbiter:
//   - bus widths of the as4c4m32s_controller command port
//   - command encodings (code 3 is reserved and behaves as NOP)
//   - owner encodings as reported on o_Owner
//   - arbiter FSM state enum
// ---------------------------------------------------------------------------
package sdram_pkg;

    localparam int CMD_W  = 2;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_RSVD  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        OWNER_INIT = 2'd0,
        OWNER_FR   = 2'd1,
        OWNER_PR   = 2'd2,
        OWNER_NONE = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_OWN,
        ST_WAIT
    } state_e;

    // The reserved code must never reach the controller as anything but NOP.
    function automatic logic [CMD_W-1:0] cmd_sanitize(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_RSVD) ? CMD_NOP : cmd;
    endfunction

    function automatic logic cmd_is_active(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_arbiter_if
// Bundles every requester, controller and status signal of the arbiter.
//   modport slave  : the arbiter side (sdram_arbiter)
//   modport master : the environment side (requesters + controller model)
// Clock and reset are kept outside the interface.
// ---------------------------------------------------------------------------
interface sdram_arbiter_if;
    import sdram_pkg::*;

    // Memory initializer
    logic              i_SDRAM_Initialized;
    logic [CMD_W-1:0]  i_MI_Command;
    logic [ADDR_W-1:0] i_MI_Data_Address;
    logic [DATA_W-1:0] i_MI_Data_Write;
    // Frame reader
    logic              i_FR_Request;
    logic [CMD_W-1:0]  i_FR_Command;
    logic [ADDR_W-1:0] i_FR_Data_Address;
    // Fractal processor
    logic              i_PR_Request;
    logic [CMD_W-1:0]  i_PR_Command;
    logic [ADDR_W-1:0] i_PR_Data_Address;
    logic [DATA_W-1:0] i_PR_Data_Write;
    // Controller completion strobes
    logic              i_Data_Read_Valid;
    logic              i_Data_Write_Done;
    // Arbiter outputs
    logic              o_FR_Grant;
    logic              o_PR_Grant;
    logic [CMD_W-1:0]  o_Command;
    logic [ADDR_W-1:0] o_Data_Address;
    logic [DATA_W-1:0] o_Data_Write;
    logic [1:0]        o_Owner;
    logic              o_Error;

    modport slave (
        input  i_SDRAM_Initialized, i_MI_Command, i_MI_Data_Address, i_MI_Data_Write,
        input  i_FR_Request, i_FR_Command, i_FR_Data_Address,
        input  i_PR_Request, i_PR_Command, i_PR_Data_Address, i_PR_Data_Write,
        input  i_Data_Read_Valid, i_Data_Write_Done,
        output o_FR_Grant, o_PR_Grant, o_Command, o_Data_Address, o_Data_Write,
        output o_Owner, o_Error
    );

    modport master (
        output i_SDRAM_Initialized, i_MI_Command, i_MI_Data_Address, i_MI_Data_Write,
        output i_FR_Request, i_FR_Command, i_FR_Data_Address,
        output i_PR_Request, i_PR_Command, i_PR_Data_Address, i_PR_Data_Write,
        output i_Data_Read_Valid, i_Data_Write_Done,
        input  o_FR_Grant, o_PR_Grant, o_Command, o_Data_Address, o_Data_Write,
        input  o_Owner, o_Error
    );

endinterface

// File: rtl/sdram_arbiter_txn_tracker.sv
// ---------------------------------------------------------------------------
// txn_tracker
// Follows one outstanding SDRAM transaction from issue to completion.
//   clk, srst        : clock, synchronous active-high reset
//   start            : a command is being issued this cycle (latch type)
//   start_read       : issued command is a READ (else WRITE)
//   active           : arbiter is in WAIT; strobes are ignored otherwise
//   data_read_valid  : one beat of read data from the controller
//   data_write_done  : write completion from the controller
//   done             : transaction completes this cycle
//   timeout          : WAIT has lasted TIMEOUT_CYCLES cycles without done
// ---------------------------------------------------------------------------
module txn_tracker #(
    parameter int READ_BURST_LENGTH = 8,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic clk,
    input  logic srst,
    input  logic start,
    input  logic start_read,
    input  logic active,
    input  logic data_read_valid,
    input  logic data_write_done,
    output logic done,
    output logic timeout
);

    localparam int BURST_W = (READ_BURST_LENGTH > 1) ? $clog2(READ_BURST_LENGTH) : 1;
    localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(READ_BURST_LENGTH - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    logic               is_read_q,   is_read_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [TO_W-1:0]    wait_cnt_q,  wait_cnt_d;
    logic               read_beat;

    // Strobes that do not match the latched type are simply not counted.
    assign read_beat = active && is_read_q && data_read_valid;
    assign done      = (read_beat && (burst_cnt_q == BURST_LAST))
                     || (active && !is_read_q && data_write_done);
    // A completion in the very last allowed cycle wins over the timeout.
    assign timeout   = active && !done && (wait_cnt_q == TO_LAST);

    always_comb begin
        is_read_d   = is_read_q;
        burst_cnt_d = burst_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (start) begin
            is_read_d   = start_read;
            burst_cnt_d = '0;
            wait_cnt_d  = '0;
        end else if (active) begin
            if (read_beat) begin
                burst_cnt_d = burst_cnt_q + BURST_W'(1);
            end
            if (wait_cnt_q != TO_LAST) begin
                wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            is_read_q   <= 1'b0;
            burst_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            is_read_q   <= is_read_d;
            burst_cnt_q <= burst_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
// Shares the single as4c4m32s_controller command port between the memory
// initializer, the frame reader and the fractal processor (MEM_CLK domain).
//   i_Clk   : MEM_CLK
//   i_Reset : synchronous, active-high
//   bus     : sdram_arbiter_if.slave -- requester commands/addresses/data,
//             request/grant handshakes, controller strobes, o_Owner, o_Error
// Flow: INIT (initializer passthrough) -> IDLE (arbitrate) -> OWN (owner's
// command passes through) -> WAIT (track completion) -> IDLE.
// ---------------------------------------------------------------------------
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int READ_BURST_LENGTH = 8,
    parameter int FR_MAX_TXNS       = 4,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    sdram_arbiter_if.slave bus
);

    localparam int STREAK_W = $clog2(FR_MAX_TXNS + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FR_MAX_TXNS);

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic                fr_grant_q,  fr_grant_d;
    logic                pr_grant_q,  pr_grant_d;
    logic                error_q,     error_d;
    logic [STREAK_W-1:0] fr_streak_q, fr_streak_d;

    // Current owner's view of its requester port.
    logic              own_req;
    logic [CMD_W-1:0]  own_cmd;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              own_issue;
    logic              pr_wins;

    logic              txn_done;
    logic              txn_timeout;

    logic [CMD_W-1:0]  cmd_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] wdata_out;

    always_comb begin
        own_req   = 1'b0;
        own_cmd   = CMD_NOP;
        own_addr  = '0;
        own_wdata = '0;
        case (owner_q)
            OWNER_FR: begin
                own_req  = bus.i_FR_Request;
                own_cmd  = bus.i_FR_Command;
                own_addr = bus.i_FR_Data_Address;
            end
            OWNER_PR: begin
                own_req   = bus.i_PR_Request;
                own_cmd   = bus.i_PR_Command;
                own_addr  = bus.i_PR_Data_Address;
                own_wdata = bus.i_PR_Data_Write;
            end
            default: ;
        endcase
    end

    assign own_issue = (state_q == ST_OWN) && cmd_is_active(own_cmd);
    // Processor jumps the queue only once the frame reader has used its quota.
    assign pr_wins   = bus.i_PR_Request && (fr_streak_q >= STREAK_MAX);

    txn_tracker #(
        .READ_BURST_LENGTH (READ_BURST_LENGTH),
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
    ) u_txn_tracker (
        .clk             (i_Clk),
        .srst            (i_Reset),
        .start           (own_issue),
        .start_read      (own_cmd == CMD_READ),
        .active          (state_q == ST_WAIT),
        .data_read_valid (bus.i_Data_Read_Valid),
        .data_write_done (bus.i_Data_Write_Done),
        .done            (txn_done),
        .timeout         (txn_timeout)
    );

    // Command port mux: only INIT and OWN ever forward a non-NOP command.
    always_comb begin
        cmd_out   = CMD_NOP;
        addr_out  = '0;
        wdata_out = '0;
        case (state_q)
            ST_INIT: begin
                cmd_out   = cmd_sanitize(bus.i_MI_Command);
                addr_out  = bus.i_MI_Data_Address;
                wdata_out = bus.i_MI_Data_Write;
            end
            ST_OWN: begin
                cmd_out   = cmd_sanitize(own_cmd);
                addr_out  = own_addr;
                wdata_out = own_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        fr_grant_d  = fr_grant_q;
        pr_grant_d  = pr_grant_q;
        error_d     = error_q;
        fr_streak_d = fr_streak_q;
        case (state_q)
            ST_INIT: begin
                if (bus.i_SDRAM_Initialized) begin
                    state_d = ST_IDLE;
                    owner_d = OWNER_NONE;
                end
            end
            ST_IDLE: begin
                if (bus.i_FR_Request && !pr_wins) begin
                    state_d    = ST_OWN;
                    owner_d    = OWNER_FR;
                    fr_grant_d = 1'b1;
                end else if (bus.i_PR_Request) begin
                    state_d    = ST_OWN;
                    owner_d    = OWNER_PR;
                    pr_grant_d = 1'b1;
                end
            end
            ST_OWN: begin
                // An issued command is honoured even if the request drops with it.
                if (own_issue) begin
                    state_d = ST_WAIT;
                end else if (!own_req) begin
                    state_d    = ST_IDLE;
                    owner_d    = OWNER_NONE;
                    fr_grant_d = 1'b0;
                    pr_grant_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (txn_done || txn_timeout) begin
                    state_d    = ST_IDLE;
                    owner_d    = OWNER_NONE;
                    fr_grant_d = 1'b0;
                    pr_grant_d = 1'b0;
                end
                if (txn_done) begin
                    if (owner_q == OWNER_PR) begin
                        fr_streak_d = '0;
                    end else if (fr_streak_q < STREAK_MAX) begin
                        fr_streak_d = fr_streak_q + STREAK_W'(1);
                    end
                end else if (txn_timeout) begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        // Fairness only matters while the processor is actually waiting.
        if (!bus.i_PR_Request) begin
            fr_streak_d = '0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= ST_INIT;
            owner_q     <= OWNER_INIT;
            fr_grant_q  <= 1'b0;
            pr_grant_q  <= 1'b0;
            error_q     <= 1'b0;
            fr_streak_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            fr_grant_q  <= fr_grant_d;
            pr_grant_q  <= pr_grant_d;
            error_q     <= error_d;
            fr_streak_q <= fr_streak_d;
        end
    end

    assign bus.o_FR_Grant     = fr_grant_q;
    assign bus.o_PR_Grant     = pr_grant_q;
    assign bus.o_Owner        = owner_q;
    assign bus.o_Error        = error_q;
    assign bus.o_Command      = cmd_out;
    assign bus.o_Data_Address = addr_out;
    assign bus.o_Data_Write   = wdata_out;

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed stimulus for sdram_arbiter with hand-computed expected values.
// Inputs change 1 ns after each rising edge; outputs are sampled then or
// 1 ns later for combinational paths.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

    logic clk = 1'b0;
    logic srst;
    int   n_checks = 0;
    int   n_fail   = 0;

    sdram_arbiter_if bus();

    sdram_arbiter #(
        .READ_BURST_LENGTH (8),
        .FR_MAX_TXNS       (4),
        .TIMEOUT_CYCLES    (1024)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (srst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Frame reader already owns the port: one READ plus a full burst.
    task automatic fr_read_txn();
        bus.i_FR_Command = 2'd1;
        tick();
        bus.i_FR_Command      = 2'd0;
        bus.i_Data_Read_Valid = 1'b1;
        tick(8);
        bus.i_Data_Read_Valid = 1'b0;
    endtask

    initial begin
        srst                    = 1'b1;
        bus.i_SDRAM_Initialized = 1'b0;
        bus.i_MI_Command        = 2'd0;
        bus.i_MI_Data_Address   = '0;
        bus.i_MI_Data_Write     = '0;
        bus.i_FR_Request        = 1'b0;
        bus.i_FR_Command        = 2'd0;
        bus.i_FR_Data_Address   = '0;
        bus.i_PR_Request        = 1'b0;
        bus.i_PR_Command        = 2'd0;
        bus.i_PR_Data_Address   = '0;
        bus.i_PR_Data_Write     = '0;
        bus.i_Data_Read_Valid   = 1'b0;
        bus.i_Data_Write_Done   = 1'b0;
        tick(2);
        srst = 1'b0;
        settle();
        check_eq("reset_owner",    bus.o_Owner,    0);
        check_eq("reset_fr_grant", bus.o_FR_Grant, 0);
        check_eq("reset_pr_grant", bus.o_PR_Grant, 0);
        check_eq("reset_error",    bus.o_Error,    0);
        check_eq("reset_command",  bus.o_Command,  0);

        // Initializer passthrough while not yet initialized
        bus.i_MI_Command      = 2'd2;
        bus.i_MI_Data_Address = 22'h000010;
        bus.i_MI_Data_Write   = 32'hDEADBEEF;
        settle();
        check_eq("mi_cmd",   bus.o_Command,      2);
        check_eq("mi_addr",  bus.o_Data_Address, 32'h10);
        check_eq("mi_data",  bus.o_Data_Write,   32'hDEADBEEF);
        check_eq("mi_owner", bus.o_Owner,        0);
        bus.i_MI_Command = 2'd3;
        settle();
        check_eq("mi_cmd3_nop", bus.o_Command, 0);
        // Requests ignored in INIT
        bus.i_MI_Command = 2'd0;
        bus.i_FR_Request = 1'b1;
        tick();
        check_eq("init_ignores_req", bus.o_FR_Grant, 0);
        check_eq("init_owner_held",  bus.o_Owner,    0);
        bus.i_FR_Request        = 1'b0;
        bus.i_SDRAM_Initialized = 1'b1;
        tick(2);
        check_eq("idle_owner",   bus.o_Owner,   3);
        check_eq("idle_command", bus.o_Command, 0);

        // Both request: frame reader wins first
        bus.i_FR_Request = 1'b1;
        bus.i_PR_Request = 1'b1;
        tick();
        check_eq("fr_granted",    bus.o_FR_Grant, 1);
        check_eq("pr_not_grant",  bus.o_PR_Grant, 0);
        check_eq("owner_fr",      bus.o_Owner,    1);
        // Stray valid in OWN does nothing
        bus.i_Data_Read_Valid = 1'b1;
        tick();
        bus.i_Data_Read_Valid = 1'b0;
        check_eq("stray_own_grant", bus.o_FR_Grant, 1);
        check_eq("stray_own_owner", bus.o_Owner,    1);
        bus.i_FR_Command      = 2'd1;
        bus.i_FR_Data_Address = 22'h000123;
        settle();
        check_eq("fr_read_cmd",  bus.o_Command,      1);
        check_eq("fr_read_addr", bus.o_Data_Address, 32'h123);
        tick();
        check_eq("wait_forces_nop", bus.o_Command, 0);
        bus.i_FR_Command      = 2'd0;
        bus.i_Data_Read_Valid = 1'b1;
        tick(7);
        check_eq("burst7_grant_held", bus.o_FR_Grant, 1);
        tick();
        bus.i_Data_Read_Valid = 1'b0;
        check_eq("burst_done_grant", bus.o_FR_Grant, 0);
        check_eq("burst_done_owner", bus.o_Owner,    3);
        tick();
        check_eq("fr_regranted", bus.o_FR_Grant, 1);

        // Three more FR transactions; the fourth completion hands over to PR
        for (int i = 0; i < 3; i++) begin
            logic exp_fr;
            exp_fr = (i < 2);
            fr_read_txn();
            tick();
            check_eq($sformatf("streak%0d_fr_grant", i + 2), bus.o_FR_Grant, exp_fr);
            check_eq($sformatf("streak%0d_pr_grant", i + 2), bus.o_PR_Grant, !exp_fr);
        end
        check_eq("owner_pr", bus.o_Owner, 2);

        // Processor write; extra command and read strobes during WAIT ignored
        bus.i_PR_Command      = 2'd2;
        bus.i_PR_Data_Address = 22'h2AAAAA;
        bus.i_PR_Data_Write   = 32'h12345678;
        settle();
        check_eq("pr_write_cmd",  bus.o_Command,      2);
        check_eq("pr_write_addr", bus.o_Data_Address, 32'h2AAAAA);
        check_eq("pr_write_data", bus.o_Data_Write,   32'h12345678);
        tick();
        check_eq("pr_wait_nop", bus.o_Command, 0);
        bus.i_Data_Read_Valid = 1'b1;
        tick(8);
        bus.i_Data_Read_Valid = 1'b0;
        check_eq("pr_mismatch_strobe", bus.o_PR_Grant, 1);
        check_eq("pr_wait_nop2",       bus.o_Command,  0);
        bus.i_Data_Write_Done = 1'b1;
        tick();
        bus.i_Data_Write_Done = 1'b0;
        bus.i_PR_Command      = 2'd0;
        check_eq("pr_done_grant", bus.o_PR_Grant, 0);
        check_eq("pr_done_owner", bus.o_Owner,    3);
        tick();
        check_eq("fr_after_pr", bus.o_FR_Grant, 1);
        bus.i_PR_Request = 1'b0;

        // Short burst -> timeout after 1024 WAIT cycles
        bus.i_FR_Command = 2'd1;
        tick();
        bus.i_FR_Command      = 2'd0;
        bus.i_Data_Read_Valid = 1'b1;
        tick(3);
        bus.i_Data_Read_Valid = 1'b0;
        check_eq("short_burst_no_err", bus.o_Error, 0);
        tick(1020);
        check_eq("to_1023_no_err",  bus.o_Error,    0);
        check_eq("to_1023_granted", bus.o_FR_Grant, 1);
        tick();
        check_eq("to_error",       bus.o_Error,    1);
        check_eq("to_owner_none",  bus.o_Owner,    3);
        check_eq("to_grant_drop",  bus.o_FR_Grant, 0);
        tick();
        check_eq("to_rearbitrate", bus.o_FR_Grant, 1);
        check_eq("to_error_sticky", bus.o_Error,   1);

        // Reset mid-read
        bus.i_FR_Command = 2'd1;
        tick();
        bus.i_FR_Command      = 2'd0;
        bus.i_Data_Read_Valid = 1'b1;
        tick(2);
        srst                    = 1'b1;
        bus.i_SDRAM_Initialized = 1'b0;
        tick();
        srst = 1'b0;
        check_eq("rst_fr_grant", bus.o_FR_Grant, 0);
        check_eq("rst_pr_grant", bus.o_PR_Grant, 0);
        check_eq("rst_owner",    bus.o_Owner,    0);
        check_eq("rst_error",    bus.o_Error,    0);
        tick(8);
        bus.i_Data_Read_Valid = 1'b0;
        check_eq("stray_init_owner", bus.o_Owner,    0);
        check_eq("stray_init_grant", bus.o_FR_Grant, 0);
        bus.i_SDRAM_Initialized = 1'b1;
        tick(2);
        check_eq("post_rst_fr_grant", bus.o_FR_Grant, 1);

        // Owner drops its request with NOP -> back to IDLE
        bus.i_FR_Request = 1'b0;
        tick();
        settle();
        check_eq("drop_grant",   bus.o_FR_Grant, 0);
        check_eq("drop_owner",   bus.o_Owner,    3);
        check_eq("drop_command", bus.o_Command,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
